// File: rtl/m_ttime_ctrl_if.sv
// CSR-side read/write bus of the ttime controller.
// master = CSR mux, slave = m_ttime_ctrl.
interface m_ttime_ctrl_if;
    logic        rd_req;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic        rd_ack;
    logic        wr_req;
    logic [1:0]  wr_sel;
    logic [31:0] wr_data;

    modport master (
        output rd_req, rd_sel, wr_req, wr_sel, wr_data,
        input  rd_data, rd_ack
    );

    modport slave (
        input  rd_req, rd_sel, wr_req, wr_sel, wr_data,
        output rd_data, rd_ack
    );
endinterface

// File: rtl/m_ttime_ctrl.sv
// 64-bit ttime accumulator with deferred carry, tear-free
// CSR reads and a timer compare raising mtip.
module m_ttime_ctrl #(
    parameter bit NO_CYCLECNT = 1'b0,
    parameter bit CMP_EN      = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 corerunning,
    input  logic                 instr_done,
    input  logic [5:0]           icnt,
    m_ttime_ctrl_if.slave        bus,
    output logic                 mtip,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] ttime_lo;
    logic [31:0] ttime_hi;
    logic [63:0] cmp;
    logic [31:0] shadow_hi;
    logic        shadow_vld;
    logic        cy_pend;

    logic        acc;
    logic [5:0]  inc;
    logic [32:0] sum;
    logic        new_cy;
    logic [31:0] lo_rd;
    logic [31:0] hi_src;
    logic        wr_lo;
    logic        wr_hi;
    logic        wr_clo;
    logic        wr_chi;
    logic        rd_go;
    logic        hi_take;

    assign busy = cy_pend;

    // Increment, write decode and read-path helper values.
    always_comb begin
        acc     = instr_done & corerunning;
        inc     = NO_CYCLECNT ? 6'd1 : icnt;
        sum     = {1'b0, ttime_lo} + {27'b0, inc};
        new_cy  = acc & sum[32];
        lo_rd   = acc ? sum[31:0] : ttime_lo;
        hi_src  = shadow_vld ? shadow_hi : ttime_hi;
        wr_lo   = bus.wr_req & (bus.wr_sel == 2'b00);
        wr_hi   = bus.wr_req & (bus.wr_sel == 2'b01);
        wr_clo  = bus.wr_req & (bus.wr_sel == 2'b10) & CMP_EN;
        wr_chi  = bus.wr_req & (bus.wr_sel == 2'b11) & CMP_EN;
        rd_go   = (state == IDLE) & bus.rd_req;
        hi_take = (rd_go & bus.rd_sel & ~cy_pend)
                | ((state == WAIT) & ~cy_pend);
    end

    // Counter words, deferred carry, compare register and mtip.
    always_ff @(posedge clk) begin
        if (rst) begin
            ttime_lo <= 32'd0;
            ttime_hi <= 32'd0;
            cmp      <= '1;
            cy_pend  <= 1'b0;
            mtip     <= 1'b0;
        end else begin
            if (wr_lo)
                ttime_lo <= bus.wr_data;
            else if (acc)
                ttime_lo <= sum[31:0];

            if (wr_hi)
                ttime_hi <= bus.wr_data;
            else if (cy_pend)
                ttime_hi <= ttime_hi + 32'd1;

            if (wr_hi)
                cy_pend <= 1'b0;
            else
                cy_pend <= new_cy & ~wr_lo;

            if (wr_clo)
                cmp[31:0] <= bus.wr_data;
            if (wr_chi)
                cmp[63:32] <= bus.wr_data;

            // a half-propagated value must not toggle mtip
            if (!cy_pend)
                mtip <= CMP_EN && ({ttime_hi, ttime_lo} >= cmp);
        end
    end

    // Read FSM with high-word shadow for tear-free 64-bit reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bus.rd_ack  <= 1'b0;
            bus.rd_data <= 32'd0;
            shadow_hi  <= 32'd0;
            shadow_vld <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    bus.rd_ack <= 1'b0;
                    if (bus.rd_req) begin
                        if (bus.rd_sel & cy_pend) begin
                            state <= WAIT;
                        end else begin
                            bus.rd_ack  <= 1'b1;
                            bus.rd_data <= bus.rd_sel ? hi_src : lo_rd;
                            state      <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (!cy_pend) begin
                        bus.rd_ack  <= 1'b1;
                        bus.rd_data <= hi_src;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    bus.rd_ack <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    bus.rd_ack <= 1'b0;
                    state     <= IDLE;
                end
            endcase

            if (rd_go & ~bus.rd_sel)
                shadow_hi <= ttime_hi
                           + {31'b0, cy_pend | new_cy};

            if (bus.wr_req)
                shadow_vld <= 1'b0;
            else if (rd_go & ~bus.rd_sel)
                shadow_vld <= 1'b1;
            else if (hi_take)
                shadow_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_m_ttime_ctrl.sv
// Directed bench for m_ttime_ctrl: read responses are
// checked by a scoreboard monitor, levels checked inline.
module tb_m_ttime_ctrl;

    typedef struct {
        logic [31:0] data;
        int          at;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic corerunning = 1'b1;
    logic instr_done = 1'b0;
    logic [5:0] icnt = 6'd0;
    logic mtip, busy;

    logic corerunning1 = 1'b1;
    logic instr_done1 = 1'b0;
    logic [5:0] icnt1 = 6'd0;
    logic mtip1, busy1;

    int cyc = 0;
    int nvec = 0;
    int nerr = 0;
    exp_t q0[$];
    exp_t q1[$];

    m_ttime_ctrl_if if0 ();
    m_ttime_ctrl_if if1 ();

    m_ttime_ctrl #(.NO_CYCLECNT(1'b0), .CMP_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .corerunning(corerunning),
        .instr_done(instr_done), .icnt(icnt), .bus(if0),
        .mtip(mtip), .busy(busy)
    );

    m_ttime_ctrl #(.NO_CYCLECNT(1'b1), .CMP_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .corerunning(corerunning1),
        .instr_done(instr_done1), .icnt(icnt1), .bus(if1),
        .mtip(mtip1), .busy(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // scoreboard monitors
    always @(negedge clk) begin
        exp_t e;
        if (if0.rd_ack === 1'b1) begin
            if (q0.size() == 0) begin
                chk("rd0_unexpected_ack", 1, 0);
            end else begin
                e = q0.pop_front();
                chk("rd0_data", {32'b0, if0.rd_data}, {32'b0, e.data});
                chk("rd0_latency", cyc, e.at);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (if1.rd_ack === 1'b1) begin
            if (q1.size() == 0) begin
                chk("rd1_unexpected_ack", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("rd1_data", {32'b0, if1.rd_data}, {32'b0, e.data});
                chk("rd1_latency", cyc, e.at);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic pulse(input int n, input logic [5:0] ic);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            instr_done = 1'b1;
            icnt = ic;
        end
        @(negedge clk);
        instr_done = 1'b0;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] d);
        @(negedge clk);
        if0.wr_req = 1'b1;
        if0.wr_sel = sel;
        if0.wr_data = d;
        @(negedge clk);
        if0.wr_req = 1'b0;
    endtask

    task automatic rd(input logic sel, input logic [31:0] exp);
        @(negedge clk);
        if0.rd_req = 1'b1;
        if0.rd_sel = sel;
        q0.push_back('{exp, cyc + 1});
        @(negedge clk);
        if0.rd_req = 1'b0;
        idle(2);
    endtask

    initial begin
        if0.rd_req = 1'b0; if0.rd_sel = 1'b0;
        if0.wr_req = 1'b0; if0.wr_sel = 2'b00; if0.wr_data = 32'd0;
        if1.rd_req = 1'b0; if1.rd_sel = 1'b0;
        if1.wr_req = 1'b0; if1.wr_sel = 2'b00; if1.wr_data = 32'd0;

        do_reset();
        chk("rst_busy", {63'b0, busy}, 0);
        chk("rst_mtip", {63'b0, mtip}, 0);
        chk("rst_ack", {63'b0, if0.rd_ack}, 0);
        chk("rst_rdata", {32'b0, if0.rd_data}, 0);

        // 10 x 5 cycles
        pulse(10, 6'd5);
        idle(1);
        rd(1'b0, 32'd50);
        rd(1'b1, 32'd0);

        // low-word wrap, busy exactly one cycle
        do_reset();
        wr(2'b00, 32'hFFFF_FFF0);
        @(negedge clk);
        instr_done = 1'b1; icnt = 6'd20;
        @(negedge clk);
        instr_done = 1'b0;
        chk("carry_busy_hi", {63'b0, busy}, 1);
        @(negedge clk);
        chk("carry_busy_lo", {63'b0, busy}, 0);
        rd(1'b0, 32'd4);
        rd(1'b1, 32'd1);
        rd(1'b1, 32'd1);

        // high read in the carry cycle goes through WAIT
        do_reset();
        wr(2'b00, 32'hFFFF_FFF0);
        @(negedge clk);
        instr_done = 1'b1; icnt = 6'd20;
        @(negedge clk);
        instr_done = 1'b0;
        if0.rd_req = 1'b1; if0.rd_sel = 1'b1;
        q0.push_back('{32'd1, cyc + 2});
        @(negedge clk);
        if0.rd_req = 1'b0;
        idle(3);

        // low read with a carrying add in the same cycle
        do_reset();
        wr(2'b00, 32'hFFFF_FFFF);
        @(negedge clk);
        instr_done = 1'b1; icnt = 6'd3;
        if0.rd_req = 1'b1; if0.rd_sel = 1'b0;
        q0.push_back('{32'd2, cyc + 1});
        @(negedge clk);
        instr_done = 1'b0;
        if0.rd_req = 1'b0;
        idle(2);
        rd(1'b1, 32'd1);

        // compare / mtip
        do_reset();
        wr(2'b11, 32'd0);
        wr(2'b10, 32'd100);
        pulse(33, 6'd3);
        idle(3);
        chk("mtip_99", {63'b0, mtip}, 0);
        @(negedge clk);
        instr_done = 1'b1; icnt = 6'd1;
        @(negedge clk);
        instr_done = 1'b0;
        chk("mtip_100_same", {63'b0, mtip}, 0);
        @(negedge clk);
        chk("mtip_100_next", {63'b0, mtip}, 1);
        wr(2'b11, 32'd1);
        chk("mtip_cmphi_old", {63'b0, mtip}, 1);
        @(negedge clk);
        chk("mtip_cmphi_new", {63'b0, mtip}, 0);
        rd(1'b0, 32'd100);

        // corerunning low ignores retirements
        corerunning = 1'b0;
        pulse(5, 6'd7);
        corerunning = 1'b1;
        idle(1);
        rd(1'b0, 32'd100);

        // full 64-bit wrap
        wr(2'b01, 32'hFFFF_FFFF);
        wr(2'b00, 32'hFFFF_FFFE);
        pulse(1, 6'd2);
        idle(2);
        rd(1'b1, 32'd0);
        rd(1'b0, 32'd0);

        // simultaneous write and read returns pre-write value
        @(negedge clk);
        if0.wr_req = 1'b1; if0.wr_sel = 2'b00; if0.wr_data = 32'd123;
        if0.rd_req = 1'b1; if0.rd_sel = 1'b0;
        instr_done = 1'b1; icnt = 6'd9;
        q0.push_back('{32'd9, cyc + 1});
        @(negedge clk);
        if0.wr_req = 1'b0; if0.rd_req = 1'b0; instr_done = 1'b0;
        idle(2);
        rd(1'b0, 32'd123);
        pulse(1, 6'd0);
        rd(1'b0, 32'd123);
        rd(1'b1, 32'd0);

        // instruction-counter variant
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            instr_done1 = 1'b1; icnt1 = 6'd40;
        end
        @(negedge clk);
        instr_done1 = 1'b0;
        corerunning1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            instr_done1 = 1'b1;
        end
        @(negedge clk);
        instr_done1 = 1'b0;
        corerunning1 = 1'b1;
        @(negedge clk);
        if1.rd_req = 1'b1; if1.rd_sel = 1'b0;
        q1.push_back('{32'd7, cyc + 1});
        @(negedge clk);
        if1.rd_req = 1'b0;

        idle(10);
        chk("q0_drain", q0.size(), 0);
        chk("q1_drain", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
